// File: rtl/pwm_generator.sv
// pwm_generator: fixed-ratio PWM source.
// o_pulse is high for PULSE_DURATION cycles out of every PULSE_PERIOD cycles.
// The first high cycle follows the first rising edge after reset is released.
// Optional feature macro: PWM_GENERATOR_CYCLE_START_EN adds o_cycle_start,
// a one-cycle strobe on the first cycle of each period.
module pwm_generator #(
    parameter int PULSE_DURATION = 4,
    parameter int PULSE_PERIOD   = 8
) (
    input  logic i_clk,
    input  logic i_rst,
`ifdef PWM_GENERATOR_CYCLE_START_EN
    output logic o_cycle_start,
`endif
    output logic o_pulse
);

    localparam int CNT_W = (PULSE_PERIOD > 1) ? $clog2(PULSE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_PERIOD - 1);
    // One extra bit so PULSE_DURATION == PULSE_PERIOD == 2**CNT_W still compares correctly
    localparam logic [CNT_W:0] DUR = (CNT_W + 1)'(PULSE_DURATION);

    if (PULSE_PERIOD < 1) begin : g_bad_period
        $error("pwm_generator: PULSE_PERIOD must be at least 1");
    end
    if (PULSE_DURATION < 0 || PULSE_DURATION > PULSE_PERIOD) begin : g_bad_duration
        $error("pwm_generator: PULSE_DURATION must lie in 0..PULSE_PERIOD");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
`ifdef PWM_GENERATOR_CYCLE_START_EN
    logic             cycle_start_q, cycle_start_d;
`endif

    // Next-state: wrap the counter at the last period cycle, decode outputs from the pre-edge count
    always_comb begin
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        pulse_d = ({1'b0, cnt_q} < DUR);
`ifdef PWM_GENERATOR_CYCLE_START_EN
        cycle_start_d = (cnt_q == '0);
`endif
    end

    // State and registered outputs, cleared asynchronously by reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
`ifdef PWM_GENERATOR_CYCLE_START_EN
            cycle_start_q <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
`ifdef PWM_GENERATOR_CYCLE_START_EN
            cycle_start_q <= cycle_start_d;
`endif
        end
    end

    assign o_pulse = pulse_q;
`ifdef PWM_GENERATOR_CYCLE_START_EN
    assign o_cycle_start = cycle_start_q;
`endif

endmodule

// File: tb/tb_pwm_generator.sv
// Scoreboard bench for pwm_generator: six instances with different
// duration/period settings share one clock and reset. Expected output
// waveforms are hand-written per-period strings indexed by cycle number.
module tb_pwm_generator;

    localparam int N = 6;
    localparam int DUR [N] = '{6, 4, 0, 5, 1, 3};
    localparam int PER [N] = '{8, 8, 5, 5, 1, 7};

    // Bit j of a period ('1'/'0') is the expected output in cycle j after an edge-aligned period start
    string pulse_pat [N] = '{"11111100", "11110000", "00000", "11111", "1", "1110000"};
    string cs_pat    [N] = '{"10000000", "10000000", "10000", "10000", "1", "1000000"};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] pulse;
    logic [N-1:0] cs;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        pwm_generator #(
            .PULSE_DURATION(DUR[g]),
            .PULSE_PERIOD  (PER[g])
        ) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
`ifdef PWM_GENERATOR_CYCLE_START_EN
            .o_cycle_start(cs[g]),
`endif
            .o_pulse      (pulse[g])
        );
    end

`ifndef PWM_GENERATOR_CYCLE_START_EN
    assign cs = '0;
`endif

    typedef struct {
        int           k;
        logic [N-1:0] pulse;
        logic [N-1:0] cs;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   k      = 0;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Issue N edges with reset low, pushing the expected post-edge outputs for each
    task automatic run_cycles(input int n);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            e.k = k;
            for (int i = 0; i < N; i++) begin
                e.pulse[i] = (pulse_pat[i][k % pulse_pat[i].len()] == "1");
                e.cs[i]    = (cs_pat[i][k % cs_pat[i].len()] == "1");
            end
            sb.push_back(e);
            k++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s pulse[%0d]", tag, i), pulse[i], 1'b0);
`ifdef PWM_GENERATOR_CYCLE_START_EN
            check($sformatf("%s cycle_start[%0d]", tag, i), cs[i], 1'b0);
`endif
        end
        check_int({tag, " cnt u1"}, int'(g_dut[1].u_dut.cnt_q), 0);
        check_int({tag, " cnt u5"}, int'(g_dut[5].u_dut.cnt_q), 0);
    endtask

    // Monitor: compare DUT outputs against the scoreboard away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < N; i++) begin
                    check($sformatf("pulse[%0d] k=%0d", i, e.k), pulse[i], e.pulse[i]);
`ifdef PWM_GENERATOR_CYCLE_START_EN
                    check($sformatf("cycle_start[%0d] k=%0d", i, e.k), cs[i], e.cs[i]);
`endif
                end
            end
        end
    end

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        #2 check_reset_state("reset");
        #17 rst = 1'b0;                      // t=20, first edge after release at t=25
        k = 0;
        run_cycles(18);                      // u1 ends in cycle k=17: high phase, cnt=2

        @(negedge clk);
        #2;
        check("pre-abort pulse u1", pulse[1], 1'b1);
        check_int("pre-abort cnt u1", int'(g_dut[1].u_dut.cnt_q), 2);
        rst = 1'b1;                          // asynchronous, between edges
        #1 check_reset_state("async abort");

        @(posedge clk);
        @(posedge clk);
        #1 check_reset_state("reset held");
        #2 rst = 1'b0;
        k = 0;
        run_cycles(60);

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        #1;
        check_int("scoreboard drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 Parameter PULSE_DURATION, default 4: number of clock cycles o_pulse is high per period; integer 0..PULSE_PERIOD.
REQ-002 Parameter PULSE_PERIOD, default 8: total clock cycles per PWM period; integer >= 1.
REQ-003 Port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 Port o_pulse  output  1  registered PWM output.
REQ-006 Port o_cycle_start  output  1  one-cycle strobe marking the first cycle of each period; present only when PWM_GENERATOR_CYCLE_START_EN is defined.

Function
REQ-007 The block SHALL hold an internal period counter cnt of width max(1, ceil(log2(PULSE_PERIOD))) bits, counting 0..PULSE_PERIOD-1.
REQ-008 On each rising edge with i_rst low, cnt SHALL advance to cnt+1, or wrap to 0 when cnt == PULSE_PERIOD-1.
REQ-009 On the same edge, o_pulse SHALL load (cnt < PULSE_DURATION), evaluated on the pre-edge cnt value; latency is one cycle from counter to output.
REQ-010 After reset release, o_pulse SHALL be high for exactly PULSE_DURATION consecutive cycles, then low for PULSE_PERIOD-PULSE_DURATION cycles, repeating with no gaps or extra cycles.
REQ-011 The first o_pulse high SHALL start on the first rising edge after i_rst deasserts.
REQ-012 With PULSE_DURATION == 0, o_pulse SHALL remain constantly low.
REQ-013 With PULSE_DURATION == PULSE_PERIOD, o_pulse SHALL remain constantly high after the first edge.
REQ-014 With PULSE_PERIOD == 1, cnt SHALL remain 0 permanently.
REQ-015 The wrap comparison SHALL be width-safe; cnt SHALL never take a value >= PULSE_PERIOD.
REQ-016 Elaboration SHALL fail when PULSE_PERIOD < 1 or PULSE_DURATION > PULSE_PERIOD.

Reset
REQ-017 While i_rst is high: cnt = 0, o_pulse = 0, and o_cycle_start = 0 (if present), asynchronously, independent of i_clk.
REQ-018 Asserting i_rst mid-period SHALL abort the period immediately.
REQ-019 After i_rst releases, the sequence SHALL restart from REQ-011; no partial period SHALL be resumed.

Configuration
REQ-020 Macro PWM_GENERATOR_CYCLE_START_EN.
- Defined: o_cycle_start exists and is registered, loading (cnt == 0) on each edge, so it is high in exactly the first cycle of each period, aligned with the first o_pulse high cycle.
- Undefined: the port and its logic are absent.
- o_pulse behaviour is identical either way.

Verification
REQ-021 PULSE_DURATION=6, PULSE_PERIOD=8, 10 ns clock, i_rst high 20 ns then low for 200 ns -> o_pulse 0 during reset; from the first edge after release, repeating pattern 6 cycles high, 2 cycles low.
REQ-022 Defaults (4/8), i_rst asserted asynchronously mid-high phase -> o_pulse and cnt go to 0 immediately; after release, a fresh 4-high/4-low period starts.
REQ-023 PULSE_DURATION=0, PULSE_PERIOD=5, 50 cycles -> o_pulse never high.
REQ-024 PULSE_DURATION=5, PULSE_PERIOD=5, 50 cycles -> o_pulse high continuously from the first post-reset edge.
REQ-025 PULSE_DURATION=1, PULSE_PERIOD=1 and PULSE_DURATION=3, PULSE_PERIOD=7 -> correct high/low counts of 1/0 and 3/4 respectively; with PWM_GENERATOR_CYCLE_START_EN defined, o_cycle_start pulses once every 7 cycles, coincident with the o_pulse rising cycle.
